// File: rtl/am2901_slice_if.sv
// Microinstruction, operand and status bus of one am2901_slice.
// The master side drives the microword and shift inputs; the slice drives the results.
interface am2901_slice_if;
    logic [8:0] I;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] D;
    logic       Cin;
    logic       RAM0_in;
    logic       RAM3_in;
    logic       Q0_in;
    logic       Q3_in;
    logic [3:0] Y;
    logic       nG;
    logic       nP;
    logic       Cout;
    logic       OVR;
    logic       Zero;
    logic       F3;
    logic       RAM0_out;
    logic       RAM3_out;
    logic       Q0_out;
    logic       Q3_out;

    modport master (
        output I, A, B, D, Cin, RAM0_in, RAM3_in, Q0_in, Q3_in,
        input  Y, nG, nP, Cout, OVR, Zero, F3, RAM0_out, RAM3_out, Q0_out, Q3_out
    );

    modport slave (
        input  I, A, B, D, Cin, RAM0_in, RAM3_in, Q0_in, Q3_in,
        output Y, nG, nP, Cout, OVR, Zero, F3, RAM0_out, RAM3_out, Q0_out, Q3_out
    );
endinterface

// File: rtl/am2901_slice.sv
// 4-bit bit-slice ALU with 16-word register file and Q register.
// Outputs nG/nP for an external look-ahead carry generator; the carry path is purely combinational.
module am2901_slice (
    input logic          clk,
    input logic          nRST,
    am2901_slice_if.slave bus
);
    typedef enum logic [2:0] {
        SRC_AQ, SRC_AB, SRC_ZQ, SRC_ZB, SRC_ZA, SRC_DA, SRC_DQ, SRC_DZ
    } src_e;
    typedef enum logic [2:0] {
        FN_ADD, FN_SUBR, FN_SUBS, FN_OR, FN_AND, FN_NOTRS, FN_EXOR, FN_EXNOR
    } fn_e;
    typedef enum logic [2:0] {
        DST_QREG, DST_NOP, DST_RAMA, DST_RAMF, DST_RAMQD, DST_RAMD, DST_RAMQU, DST_RAMU
    } dst_e;

    logic [3:0] regs [16];
    logic [3:0] q;
    src_e       src;
    fn_e        fn;
    dst_e       dst;
    logic [3:0] a_val, b_val, r, s, rr, ss, p, g, f;
    logic       c1, c2, c3, c4, arith;
    logic       ram_we, q_we;
    logic [3:0] ram_d, q_d;

    assign src   = src_e'(bus.I[2:0]);
    assign fn    = fn_e'(bus.I[5:3]);
    assign dst   = dst_e'(bus.I[8:6]);
    assign a_val = regs[bus.A];
    assign b_val = regs[bus.B];

    always_comb begin
        r = '0;
        s = '0;
        case (src)
            SRC_AQ: begin r = a_val; s = q;     end
            SRC_AB: begin r = a_val; s = b_val; end
            SRC_ZQ: begin r = '0;    s = q;     end
            SRC_ZB: begin r = '0;    s = b_val; end
            SRC_ZA: begin r = '0;    s = a_val; end
            SRC_DA: begin r = bus.D; s = a_val; end
            SRC_DQ: begin r = bus.D; s = q;     end
            default: begin r = bus.D; s = '0;   end
        endcase
    end

    // Subtraction is done by inverting one operand; P/G are taken after inversion.
    always_comb begin
        arith = (fn == FN_ADD) || (fn == FN_SUBR) || (fn == FN_SUBS);
        rr    = (fn == FN_SUBR) ? ~r : r;
        ss    = (fn == FN_SUBS) ? ~s : s;
        p     = rr | ss;
        g     = rr & ss;
        c1    = g[0] | (p[0] & bus.Cin);
        c2    = g[1] | (p[1] & c1);
        c3    = g[2] | (p[2] & c2);
        c4    = g[3] | (p[3] & c3);
        f     = '0;
        case (fn)
            FN_ADD, FN_SUBR, FN_SUBS: f = rr ^ ss ^ {c3, c2, c1, bus.Cin};
            FN_OR:                    f = r | s;
            FN_AND:                   f = r & s;
            FN_NOTRS:                 f = ~r & s;
            FN_EXOR:                  f = r ^ s;
            default:                  f = ~(r ^ s);
        endcase
    end

    assign bus.nP       = arith ? ~(&p) : 1'b1;
    assign bus.nG       = arith ? ~(g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                                    | (p[3] & p[2] & p[1] & g[0])) : 1'b1;
    assign bus.Cout     = arith & c4;
    assign bus.OVR      = arith & (c4 ^ c3);
    assign bus.Y        = (dst == DST_RAMA) ? a_val : f;
    assign bus.Zero     = (f == 4'd0);
    assign bus.F3       = f[3];
    assign bus.RAM0_out = f[0];
    assign bus.RAM3_out = f[3];
    assign bus.Q0_out   = q[0];
    assign bus.Q3_out   = q[3];

    always_comb begin
        ram_we = 1'b0;
        ram_d  = f;
        q_we   = 1'b0;
        q_d    = f;
        case (dst)
            DST_QREG:  q_we = 1'b1;
            DST_NOP:   ;
            DST_RAMA,
            DST_RAMF:  ram_we = 1'b1;
            DST_RAMQD: begin
                ram_we = 1'b1; ram_d = {bus.RAM3_in, f[3:1]};
                q_we   = 1'b1; q_d   = {bus.Q3_in, q[3:1]};
            end
            DST_RAMD:  begin ram_we = 1'b1; ram_d = {bus.RAM3_in, f[3:1]}; end
            DST_RAMQU: begin
                ram_we = 1'b1; ram_d = {f[2:0], bus.RAM0_in};
                q_we   = 1'b1; q_d   = {q[2:0], bus.Q0_in};
            end
            default:   begin ram_we = 1'b1; ram_d = {f[2:0], bus.RAM0_in}; end
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < 16; i++) regs[i[3:0]] <= '0;
            q <= '0;
        end else begin
            if (ram_we) regs[bus.B] <= ram_d;
            if (q_we)   q <= q_d;
        end
    end
endmodule

// File: tb/tb_am2901_slice.sv
// Self-checking bench for am2901_slice: directed scenarios followed by random microwords
// compared against an arithmetic reference model of the slice.
module tb_am2901_slice;
    logic clk = 1'b0;
    logic nRST;
    int   vectors = 0;
    int   miscompares = 0;

    am2901_slice_if bus ();

    am2901_slice dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference state and expected results
    logic [3:0] m_regs [16];
    logic [3:0] m_q;
    logic [3:0] e_y, e_f;
    logic       e_ng, e_np, e_cout, e_ovr;

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_regs[i] = 4'd0;
        m_q = 4'd0;
    endtask

    task automatic model_eval();
        int unsigned av, bv, qv, r, s, rr, ss, sum, lo, fn, cin;
        av  = m_regs[bus.A];
        bv  = m_regs[bus.B];
        qv  = m_q;
        r   = 0;
        s   = 0;
        fn  = bus.I[5:3];
        cin = bus.Cin;
        case (bus.I[2:0])
            3'd0: begin r = av;    s = qv; end
            3'd1: begin r = av;    s = bv; end
            3'd2: begin r = 0;     s = qv; end
            3'd3: begin r = 0;     s = bv; end
            3'd4: begin r = 0;     s = av; end
            3'd5: begin r = bus.D; s = av; end
            3'd6: begin r = bus.D; s = qv; end
            default: begin r = bus.D; s = 0; end
        endcase
        if (fn <= 2) begin
            rr     = (fn == 1) ? 15 - r : r;
            ss     = (fn == 2) ? 15 - s : s;
            sum    = rr + ss + cin;
            lo     = (rr % 8) + (ss % 8) + cin;
            e_f    = 4'(sum % 16);
            e_cout = (sum >= 16);
            e_ovr  = (sum >= 16) != (lo >= 8);
            e_np   = !((rr | ss) == 15);
            e_ng   = !(rr + ss >= 16);
        end else begin
            case (fn)
                3:       e_f = 4'(r | s);
                4:       e_f = 4'(r & s);
                5:       e_f = 4'((15 - r) & s);
                6:       e_f = 4'(r ^ s);
                default: e_f = 4'(15 - (r ^ s));
            endcase
            e_cout = 1'b0;
            e_ovr  = 1'b0;
            e_np   = 1'b1;
            e_ng   = 1'b1;
        end
        e_y = (bus.I[8:6] == 3'd2) ? 4'(av) : e_f;
    endtask

    task automatic model_commit();
        int unsigned fv, qv;
        model_eval();
        fv = e_f;
        qv = m_q;
        case (bus.I[8:6])
            3'd0: m_q = e_f;
            3'd2, 3'd3: m_regs[bus.B] = e_f;
            3'd4: begin
                m_regs[bus.B] = 4'(bus.RAM3_in * 8 + fv / 2);
                m_q           = 4'(bus.Q3_in * 8 + qv / 2);
            end
            3'd5: m_regs[bus.B] = 4'(bus.RAM3_in * 8 + fv / 2);
            3'd6: begin
                m_regs[bus.B] = 4'((fv * 2) % 16 + bus.RAM0_in);
                m_q           = 4'((qv * 2) % 16 + bus.Q0_in);
            end
            3'd7: m_regs[bus.B] = 4'((fv * 2) % 16 + bus.RAM0_in);
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        model_eval();
        chk("Y",        bus.Y,              e_y);
        chk("nG",       4'(bus.nG),         4'(e_ng));
        chk("nP",       4'(bus.nP),         4'(e_np));
        chk("Cout",     4'(bus.Cout),       4'(e_cout));
        chk("OVR",      4'(bus.OVR),        4'(e_ovr));
        chk("Zero",     4'(bus.Zero),       4'(e_f == 4'd0));
        chk("F3",       4'(bus.F3),         4'(e_f[3]));
        chk("RAM0_out", 4'(bus.RAM0_out),   4'(e_f[0]));
        chk("RAM3_out", 4'(bus.RAM3_out),   4'(e_f[3]));
        chk("Q0_out",   4'(bus.Q0_out),     4'(m_q[0]));
        chk("Q3_out",   4'(bus.Q3_out),     4'(m_q[3]));
    endtask

    // Drive a microword (dest, func, src) and operands, then let it settle.
    task automatic set(input logic [2:0] dst, input logic [2:0] fn, input logic [2:0] src,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                       input logic cin);
        bus.I   = {dst, fn, src};
        bus.A   = a;
        bus.B   = b;
        bus.D   = d;
        bus.Cin = cin;
        #1;
    endtask

    task automatic step();
        check_all();
        @(posedge clk);
        if (nRST) model_commit();
        @(negedge clk);
    endtask

    task automatic load(input logic [3:0] b, input logic [3:0] v);
        set(3'd3, 3'd0, 3'd7, 4'd0, b, v, 1'b0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        nRST = 1'b0;
        bus.RAM0_in = 1'b0; bus.RAM3_in = 1'b0;
        bus.Q0_in   = 1'b0; bus.Q3_in   = 1'b0;
        model_clear();
        set(3'd1, 3'd0, 3'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        chk("rst_Y",    bus.Y,            4'd0);
        chk("rst_Zero", 4'(bus.Zero),     4'd1);
        chk("rst_nG",   4'(bus.nG),       4'd1);
        chk("rst_nP",   4'(bus.nP),       4'd1);
        chk("rst_Cout", 4'(bus.Cout),     4'd0);
        chk("rst_OVR",  4'(bus.OVR),      4'd0);
        chk("rst_Q0",   4'(bus.Q0_out),   4'd0);
        chk("rst_Q3",   4'(bus.Q3_out),   4'd0);
        @(negedge clk);
        nRST = 1'b1;

        // Asynchronous reset mid-cycle; the edge seen during reset must not write.
        load(4'd3, 4'd5);
        #2 nRST = 1'b0;
        model_clear();
        set(3'd1, 3'd0, 3'd3, 4'd0, 4'd3, 4'd0, 1'b0);
        chk("arst_Y",    bus.Y,        4'd0);
        chk("arst_Zero", 4'(bus.Zero), 4'd1);
        set(3'd3, 3'd0, 3'd7, 4'd0, 4'd3, 4'd9, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #2 nRST = 1'b1;
        set(3'd1, 3'd0, 3'd3, 4'd0, 4'd3, 4'd0, 1'b0);
        chk("arst_nowrite", bus.Y, 4'd0);
        @(negedge clk);

        load(4'd3, 4'd5);
        set(3'd1, 3'd0, 3'd3, 4'd0, 4'd3, 4'd0, 1'b0);
        chk("load_Y",    bus.Y,        4'd5);
        chk("load_Zero", 4'(bus.Zero), 4'd0);

        load(4'd1, 4'd3);
        load(4'd2, 4'd5);
        set(3'd1, 3'd1, 3'd1, 4'd1, 4'd2, 4'd0, 1'b1);
        chk("sub_Y",    bus.Y,        4'd2);
        chk("sub_Cout", 4'(bus.Cout), 4'd1);
        chk("sub_nG",   4'(bus.nG),   4'd0);
        chk("sub_nP",   4'(bus.nP),   4'd1);
        chk("sub_OVR",  4'(bus.OVR),  4'd0);
        check_all();

        load(4'd0, 4'd15);
        set(3'd1, 3'd0, 3'd4, 4'd0, 4'd0, 4'd0, 1'b1);
        chk("prop_Y",    bus.Y,        4'd0);
        chk("prop_Zero", 4'(bus.Zero), 4'd1);
        chk("prop_Cout", 4'(bus.Cout), 4'd1);
        chk("prop_nP",   4'(bus.nP),   4'd0);
        chk("prop_nG",   4'(bus.nG),   4'd1);
        chk("prop_OVR",  4'(bus.OVR),  4'd0);
        set(3'd1, 3'd0, 3'd4, 4'd0, 4'd0, 4'd0, 1'b0);
        chk("prop0_Y",    bus.Y,        4'd15);
        chk("prop0_Cout", 4'(bus.Cout), 4'd0);
        chk("prop0_nP",   4'(bus.nP),   4'd0);

        load(4'd4, 4'b1001);
        bus.RAM3_in = 1'b1;
        set(3'd5, 3'd0, 3'd3, 4'd0, 4'd4, 4'd0, 1'b0);
        chk("shd_RAM0", 4'(bus.RAM0_out), 4'd1);
        step();
        bus.RAM3_in = 1'b0;
        set(3'd1, 3'd0, 3'd3, 4'd0, 4'd4, 4'd0, 1'b0);
        chk("shd_reg4", bus.Y, 4'b1100);

        set(3'd0, 3'd0, 3'd7, 4'd0, 4'd0, 4'd6, 1'b0);
        step();
        bus.Q0_in = 1'b1;
        set(3'd6, 3'd0, 3'd3, 4'd0, 4'd8, 4'd0, 1'b0);
        chk("qsu_Q3", 4'(bus.Q3_out), 4'd0);
        step();
        bus.Q0_in = 1'b0;
        set(3'd1, 3'd0, 3'd2, 4'd0, 4'd0, 4'd0, 1'b0);
        chk("qsu_Q", bus.Y, 4'b1101);

        load(4'd5, 4'd5);
        set(3'd3, 3'd0, 3'd1, 4'd5, 4'd5, 4'd0, 1'b0);
        chk("rmw_Y", bus.Y, 4'd10);
        step();
        set(3'd1, 3'd0, 3'd3, 4'd0, 4'd5, 4'd0, 1'b0);
        chk("rmw_reg", bus.Y, 4'd10);
        @(negedge clk);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                #1 nRST = 1'b0;
                model_clear();
                #1 nRST = 1'b1;
            end
            bus.RAM0_in = 1'($urandom);
            bus.RAM3_in = 1'($urandom);
            bus.Q0_in   = 1'($urandom);
            bus.Q3_in   = 1'($urandom);
            set(3'($urandom), 3'($urandom), 3'($urandom), 4'($urandom), 4'($urandom),
                4'($urandom), 1'($urandom));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
